// File: rtl/ammod_pulse_sched.sv
// Time-triggered pulse scheduler feeding the ammod modulator.
// Queues pulse commands and fires each one when tcnt reaches its start time.
module ammod_pulse_sched #(
   parameter int DEPTH = 4,
   parameter int AW    = 12,
   parameter int LW    = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [26:0]   tcnt,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [31:0]   cmd_freq,
   input  logic [16:0]   cmd_pini,
   input  logic [15:0]   cmd_ampx,
   input  logic [26:0]   cmd_tstart,
   input  logic [AW-1:0] cmd_envaddr,
   input  logic [LW-1:0] cmd_len,
   output logic          gate,
   output logic [31:0]   freq32,
   output logic [16:0]   pini,
   output logic [15:0]   ampx,
   output logic [AW-1:0] env_addr,
   output logic          env_rd,
   output logic          busy,
   output logic          done,
   output logic          late
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   P_ONE = 1;
   localparam logic [AW-1:0] A_ONE = 1;
   localparam logic [LW-1:0] L_ONE = 1;

   typedef struct packed {
      logic [31:0]   freq;
      logic [16:0]   pini;
      logic [15:0]   ampx;
      logic [26:0]   tstart;
      logic [AW-1:0] envaddr;
      logic [LW-1:0] len;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_PLAY
   } state_t;

   cmd_t          mem_q [DEPTH];
   cmd_t          mem_d [DEPTH];
   logic [PW:0]   wr_ptr_q, wr_ptr_d;
   logic [PW:0]   rd_ptr_q, rd_ptr_d;
   state_t        state_q, state_d;
   logic          gate_q, gate_d;
   logic          done_q, done_d;
   logic          late_q, late_d;
   logic [31:0]   freq_q, freq_d;
   logic [16:0]   pini_q, pini_d;
   logic [15:0]   ampx_q, ampx_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [LW-1:0] cnt_q, cnt_d;

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   cmd_t          head;
   cmd_t          cmd_in;
   logic [26:0]   diff;
   logic          due;

   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign push   = cmd_valid && !full;
   assign cmd_in = '{freq: cmd_freq, pini: cmd_pini,
                     ampx: cmd_ampx, tstart: cmd_tstart,
                     envaddr: cmd_envaddr, len: cmd_len};
   assign head   = mem_q[rd_ptr_q[PW-1:0]];

   // Modular distance; bit 26 clear means tstart is now or in the past.
   assign diff   = tcnt - head.tstart;
   assign due    = ~diff[26];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      state_d  = state_q;
      gate_d   = gate_q;
      done_d   = 1'b0;
      late_d   = 1'b0;
      freq_d   = freq_q;
      pini_d   = pini_q;
      ampx_d   = ampx_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      pop      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (due) begin
               pop    = 1'b1;
               freq_d = head.freq;
               pini_d = head.pini;
               ampx_d = head.ampx;
               addr_d = head.envaddr;
               cnt_d  = head.len;
               if (head.len == '0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  gate_d  = 1'b1;
                  late_d  = (diff != '0);
                  state_d = S_PLAY;
               end
            end
         end
         S_PLAY: begin
            addr_d = addr_q + A_ONE;
            cnt_d  = cnt_q - L_ONE;
            if (cnt_q == L_ONE) begin
               gate_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (push) begin
         mem_d[wr_ptr_q[PW-1:0]] = cmd_in;
         wr_ptr_d = wr_ptr_q + P_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + P_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         state_q  <= S_IDLE;
         gate_q   <= 1'b0;
         done_q   <= 1'b0;
         late_q   <= 1'b0;
         freq_q   <= '0;
         pini_q   <= '0;
         ampx_q   <= '0;
         addr_q   <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         state_q  <= state_d;
         gate_q   <= gate_d;
         done_q   <= done_d;
         late_q   <= late_d;
         freq_q   <= freq_d;
         pini_q   <= pini_d;
         ampx_q   <= ampx_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Payload storage needs no reset; the pointers define validity.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign cmd_ready = !full;
   assign gate      = gate_q;
   assign env_rd    = gate_q;
   assign freq32    = freq_q;
   assign pini      = pini_q;
   assign ampx      = ampx_q;
   assign env_addr  = addr_q;
   assign busy      = (state_q != S_IDLE) || !empty;
   assign done      = done_q;
   assign late      = late_q;

endmodule

// File: tb/tb_ammod_pulse_sched.sv
// Bench for ammod_pulse_sched: directed scenarios plus random commands,
// checked every cycle against a timeline model of pulse firing.
module tb_ammod_pulse_sched;

   localparam int DEPTH = 4;
   localparam int AW    = 12;
   localparam int LW    = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic [26:0]   tcnt;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [31:0]   cmd_freq;
   logic [16:0]   cmd_pini;
   logic [15:0]   cmd_ampx;
   logic [26:0]   cmd_tstart;
   logic [AW-1:0] cmd_envaddr;
   logic [LW-1:0] cmd_len;
   logic          gate;
   logic [31:0]   freq32;
   logic [16:0]   pini;
   logic [15:0]   ampx;
   logic [AW-1:0] env_addr;
   logic          env_rd;
   logic          busy;
   logic          done;
   logic          late;

   always #5 clk = ~clk;

   ammod_pulse_sched #(.DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
      .clk         (clk),
      .reset       (reset),
      .tcnt        (tcnt),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_freq    (cmd_freq),
      .cmd_pini    (cmd_pini),
      .cmd_ampx    (cmd_ampx),
      .cmd_tstart  (cmd_tstart),
      .cmd_envaddr (cmd_envaddr),
      .cmd_len     (cmd_len),
      .gate        (gate),
      .freq32      (freq32),
      .pini        (pini),
      .ampx        (ampx),
      .env_addr    (env_addr),
      .env_rd      (env_rd),
      .busy        (busy),
      .done        (done),
      .late        (late)
   );

   typedef struct {
      logic [31:0]   freq;
      logic [16:0]   pini;
      logic [15:0]   ampx;
      logic [26:0]   tstart;
      logic [AW-1:0] env;
      int            len;
      longint        pcyc;
   } ent_t;

   ent_t          q[$];
   longint        cyc;
   longint        last_d;
   longint        m_cyc;
   longint        d_cyc;
   int            m_len;
   logic [AW-1:0] m_env;
   bit            m_late;
   bit            act;
   bit            d_valid;
   logic [31:0]   h_freq;
   logic [16:0]   h_pini;
   logic [15:0]   h_ampx;
   int            checks;
   int            errors;
   bit            chk_en;
   bit            acc;
   int            gate_seen;
   int            done_seen;
   int            late_seen;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Signed distance now-minus-start folded into [-2^26, 2^26).
   function automatic bit is_due(input logic [26:0] t,
                                 input logic [26:0] ts,
                                 output bit lt);
      logic [26:0] raw;
      int          sd;
      raw = t - ts;
      if (int'(raw) >= (1 << 26)) sd = int'(raw) - (1 << 27);
      else sd = int'(raw);
      lt = (sd > 0);
      return (sd >= 0);
   endfunction

   task automatic tick();
      bit            playing;
      bit            lt;
      bit            dd;
      longint        e;
      logic [AW-1:0] ea;
      ent_t          h;
      ent_t          n;
      playing = act && (m_len > 0) && (cyc > m_cyc) &&
                (cyc <= m_cyc + m_len);
      @(negedge clk);
      if (chk_en) begin
         chk("gate", 32'(gate), 32'(playing));
         chk("env_rd", 32'(env_rd), 32'(playing));
         chk("done", 32'(done), 32'(d_valid && cyc == d_cyc));
         chk("late", 32'(late), 32'(act && m_late && cyc == m_cyc + 1));
         chk("busy", 32'(busy), 32'(q.size() > 0 || playing));
         chk("cmd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));
         chk("freq32", freq32, h_freq);
         chk("pini", 32'(pini), 32'(h_pini));
         chk("ampx", 32'(ampx), 32'(h_ampx));
         if (playing) begin
            ea = m_env + AW'(cyc - m_cyc - 1);
            chk("env_addr", 32'(env_addr), 32'(ea));
         end
      end
      if (gate === 1'b1) gate_seen++;
      if (done === 1'b1) done_seen++;
      if (late === 1'b1) late_seen++;
      acc = !reset && cmd_valid && (q.size() < DEPTH);
      if (reset) begin
         q.delete();
         act     = 1'b0;
         d_valid = 1'b0;
         last_d  = cyc;
         h_freq  = '0;
         h_pini  = '0;
         h_ampx  = '0;
      end else begin
         if (q.size() > 0) begin
            h = q[0];
            e = h.pcyc + 2;
            if (last_d + 1 > e) e = last_d + 1;
            dd = is_due(tcnt, h.tstart, lt);
            if (cyc >= e && dd) begin
               m_cyc   = cyc;
               m_len   = h.len;
               m_env   = h.env;
               m_late  = lt && (h.len > 0);
               act     = 1'b1;
               d_cyc   = (h.len > 0) ? cyc + h.len + 1 : cyc + 1;
               d_valid = 1'b1;
               last_d  = d_cyc;
               h_freq  = h.freq;
               h_pini  = h.pini;
               h_ampx  = h.ampx;
               void'(q.pop_front());
            end
         end
         if (acc) begin
            n.freq   = cmd_freq;
            n.pini   = cmd_pini;
            n.ampx   = cmd_ampx;
            n.tstart = cmd_tstart;
            n.env    = cmd_envaddr;
            n.len    = int'(cmd_len);
            n.pcyc   = cyc;
            q.push_back(n);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      tcnt = tcnt + 27'd1;
   endtask

   task automatic push(input logic [26:0] ts, input logic [AW-1:0] env,
                       input int len);
      int k;
      cmd_freq    = $urandom;
      cmd_pini    = 17'($urandom);
      cmd_ampx    = 16'($urandom);
      cmd_tstart  = ts;
      cmd_envaddr = env;
      cmd_len     = LW'(len);
      cmd_valid   = 1'b1;
      k = 0;
      do begin
         tick();
         k++;
      end while (!acc && k < 600);
      chk("push_accept", 32'(acc), 32'd1);
      cmd_valid = 1'b0;
   endtask

   task automatic run_until_idle(input int budget);
      int k;
      k = 0;
      while ((q.size() > 0 || cyc <= last_d) && k < budget) begin
         tick();
         k++;
      end
      chk("drain", 32'(q.size() == 0 && cyc > last_d), 32'd1);
   endtask

   task automatic clr_cnt();
      gate_seen = 0;
      done_seen = 0;
      late_seen = 0;
   endtask

   initial begin
      int k;
      reset       = 1'b1;
      tcnt        = '0;
      cmd_valid   = 1'b0;
      cmd_freq    = '0;
      cmd_pini    = '0;
      cmd_ampx    = '0;
      cmd_tstart  = '0;
      cmd_envaddr = '0;
      cmd_len     = '0;
      checks      = 0;
      errors      = 0;
      chk_en      = 1'b0;
      cyc         = 0;
      last_d      = -1;
      act         = 1'b0;
      d_valid     = 1'b0;
      h_freq      = '0;
      h_pini      = '0;
      h_ampx      = '0;
      tick();
      tick();
      reset  = 1'b0;
      chk_en = 1'b1;
      chk("rst_env_addr", 32'(env_addr), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      tick();

      // single on-time pulse
      tcnt = 27'd90;
      clr_cnt();
      push(27'd100, 12'h010, 8);
      run_until_idle(200);
      chk("s1_gates", 32'(gate_seen), 32'd8);
      chk("s1_dones", 32'(done_seen), 32'd1);
      chk("s1_lates", 32'(late_seen), 32'd0);

      // start time just past the counter wrap
      tcnt = 27'h7FF_FFFD;
      clr_cnt();
      push(27'd2, 12'h100, 3);
      run_until_idle(200);
      chk("s2_gates", 32'(gate_seen), 32'd3);
      chk("s2_lates", 32'(late_seen), 32'd0);

      // late command
      tcnt = 27'd60;
      clr_cnt();
      push(27'd50, 12'h200, 5);
      run_until_idle(200);
      chk("s3_gates", 32'(gate_seen), 32'd5);
      chk("s3_lates", 32'(late_seen), 32'd1);

      // back-pressure with nothing due
      tcnt = 27'd1000;
      clr_cnt();
      for (int i = 0; i < 6; i++) begin
         push(27'(1200 + i * 20), AW'(i * 16), 3);
         if (i == 3) chk("s4_full", 32'(cmd_ready), 32'd0);
      end
      run_until_idle(1000);
      chk("s4_gates", 32'(gate_seen), 32'd18);
      chk("s4_dones", 32'(done_seen), 32'd6);

      // reset on the third gate cycle with a command still queued
      tcnt = 27'd5000;
      push(27'd5004, 12'h300, 10);
      push(27'd5500, 12'h380, 2);
      k = 0;
      while (!(act && cyc == m_cyc + 3) && k < 100) begin
         tick();
         k++;
      end
      chk("s5_reach", 32'(act && cyc == m_cyc + 3), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("s5_env_addr", 32'(env_addr), 32'd0);
      chk("s5_busy", 32'(busy), 32'd0);
      clr_cnt();
      for (int i = 0; i < 12; i++) tick();
      chk("s5_no_done", 32'(done_seen), 32'd0);
      push(tcnt + 27'd3, 12'h040, 4);
      run_until_idle(200);
      chk("s5_gates", 32'(gate_seen), 32'd4);

      // zero length, then envelope address wrap
      clr_cnt();
      push(tcnt + 27'd2, 12'h055, 0);
      run_until_idle(100);
      chk("s6_len0_gates", 32'(gate_seen), 32'd0);
      chk("s6_len0_dones", 32'(done_seen), 32'd1);
      chk("s6_len0_lates", 32'(late_seen), 32'd0);
      push(tcnt + 27'd3, 12'hFFE, 4);
      run_until_idle(100);

      // random commands, some late, some back-to-back
      for (int i = 0; i < 24; i++) begin
         push(tcnt + 27'($urandom_range(0, 40)) - 27'd15,
              AW'($urandom), int'($urandom_range(0, 6)));
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
      end
      run_until_idle(3000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
